// File: rtl/cpu_defs.sv
// Shared CPU definitions: access width codes, fault causes, LSU state encoding, opcodes.
package cpu_defs;

    localparam logic [1:0] WIDTH_BYTE  = 2'b00;
    localparam logic [1:0] WIDTH_SHORT = 2'b01;
    localparam logic [1:0] WIDTH_WORD  = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_STR  = 4'd7;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: select generation, store replication,
// load extraction/extension and misalignment detection (purely combinational).
module lsu_align
    import cpu_defs::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        sel         = '0;
        wdata_lanes = '0;
        rdata_ext   = '0;
        misaligned  = 1'b0;
        case (width)
            WIDTH_BYTE: begin
                sel         = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            end
            WIDTH_SHORT: begin
                sel         = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{sign_ext & half_lane[15]}}, half_lane};
                misaligned  = addr_lo[0];
            end
            WIDTH_WORD: begin
                sel         = 4'b1111;
                wdata_lanes = wdata;
                rdata_ext   = rdata;
                misaligned  = |addr_lo;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single pipelined Wishbone access per request with lane steering.
// Optional watchdog timeout enabled by defining LSU_TIMEOUT_EN.
module lsu
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [1:0]        i_width,
    input  logic              i_signed,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_dst_reg,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic [3:0]        o_dst_reg,
    output logic              o_reg_we,
    output logic              o_fault,
    output logic [1:0]        o_fault_cause,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic [31:0]       o_wb_data,
    output logic [3:0]        o_wb_sel,
    output logic              o_wb_we,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    input  logic [31:0]       i_wb_data,
    input  logic              i_wb_ack,
    input  logic              i_wb_stall,
    input  logic              i_wb_err
);

    logic [1:0]        state_q;
    logic              we_q, signed_q;
    logic [1:0]        width_q, addr_lo_q, cause_q;
    logic [ADDR_W-1:2] addr_hi_q;
    logic [31:0]       wb_data_q, rdata_q;
    logic [3:0]        sel_q, dst_q;

    logic        idle, in_bus, complete, timeout_hit;
    logic [1:0]  al_width, al_addr_lo;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misaligned;

    assign idle   = (state_q == ST_IDLE);
    assign in_bus = (state_q == ST_REQ) || (state_q == ST_WAIT);

    // Align sees the live request while idle (steering/misalign) and the latched one afterwards (extraction)
    assign al_width   = idle ? i_width : width_q;
    assign al_addr_lo = idle ? i_addr[1:0] : addr_lo_q;

    lsu_align u_align (
        .width       (al_width),
        .addr_lo     (al_addr_lo),
        .sign_ext    (signed_q),
        .wdata       (i_wdata),
        .rdata       (i_wb_data),
        .sel         (al_sel),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_misaligned)
    );

    assign complete = ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !i_wb_stall))
                      && (i_wb_ack || i_wb_err);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout_hit = in_bus && !complete && (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_q <= '0;
        else if (!in_bus) cnt_q <= '0;
        else              cnt_q <= cnt_q + 8'd1;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            width_q   <= '0;
            addr_lo_q <= '0;
            addr_hi_q <= '0;
            wb_data_q <= '0;
            sel_q     <= '0;
            dst_q     <= '0;
            cause_q   <= CAUSE_NONE;
            rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (i_start) begin
                    we_q      <= i_we;
                    signed_q  <= i_signed;
                    width_q   <= i_width;
                    addr_lo_q <= i_addr[1:0];
                    addr_hi_q <= i_addr[ADDR_W-1:2];
                    wb_data_q <= al_wdata;
                    sel_q     <= al_sel;
                    dst_q     <= i_dst_reg;
                    rdata_q   <= '0;
                    cause_q   <= al_misaligned ? CAUSE_MISALIGN : CAUSE_NONE;
                    state_q   <= al_misaligned ? ST_DONE : ST_REQ;
                end
                ST_REQ, ST_WAIT: begin
                    if (complete) begin
                        state_q <= ST_DONE;
                        if (i_wb_err) cause_q <= CAUSE_BUS_ERR;
                        else if (!we_q) rdata_q <= al_rdata;
                    end else if (timeout_hit) begin
                        state_q <= ST_DONE;
                        cause_q <= CAUSE_TIMEOUT;
                    end else if ((state_q == ST_REQ) && !i_wb_stall) begin
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_busy        = !idle;
    assign o_done        = (state_q == ST_DONE);
    assign o_rdata       = rdata_q;
    assign o_dst_reg     = dst_q;
    assign o_fault       = o_done && (cause_q != CAUSE_NONE);
    assign o_fault_cause = o_done ? cause_q : CAUSE_NONE;
    assign o_reg_we      = o_done && !we_q && (cause_q == CAUSE_NONE);
    assign o_wb_addr     = {addr_hi_q, 2'b00};
    assign o_wb_data     = wb_data_q;
    assign o_wb_sel      = sel_q;
    assign o_wb_cyc      = in_bus;
    assign o_wb_stb      = (state_q == ST_REQ);
    assign o_wb_we       = in_bus && we_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus random accesses against an
// arithmetic reference model of lane selection, extension and fault timing.
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0, i_we = 1'b0, i_signed = 1'b0;
    logic [1:0]  i_width = '0;
    logic [31:0] i_addr = '0, i_wdata = '0;
    logic [3:0]  i_dst_reg = '0;
    logic        o_busy, o_done, o_reg_we, o_fault;
    logic [31:0] o_rdata, o_wb_addr, o_wb_data;
    logic [3:0]  o_dst_reg, o_wb_sel;
    logic [1:0]  o_fault_cause;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] i_wb_data = '0;
    logic        i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    lsu dut (
        .clk(clk), .reset(reset),
        .i_start(i_start), .i_we(i_we), .i_width(i_width), .i_signed(i_signed),
        .i_addr(i_addr), .i_wdata(i_wdata), .i_dst_reg(i_dst_reg),
        .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_dst_reg(o_dst_reg),
        .o_reg_we(o_reg_we), .o_fault(o_fault), .o_fault_cause(o_fault_cause),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_data(i_wb_data), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input logic [1:0] w, input logic [31:0] a, input logic sg,
                                  input logic [31:0] wd, input logic [31:0] bus,
                                  output logic mis, output logic [3:0] sel,
                                  output logic [31:0] wdl, output logic [31:0] rd);
        int unsigned off;
        int unsigned nb;
        logic [63:0] mask, v;
        off  = a % 4;
        nb   = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        mis  = (w == 2'd3) || (off % nb != 0);
        sel  = 4'(((1 << nb) - 1) << off);
        wdl  = (w == 2'd0) ? wd[7:0] * 32'h01010101 : (w == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = (64'(bus) >> (8 * off)) & mask;
        if (sg && v[8 * nb - 1]) v = v | ~mask;
        rd   = v[31:0];
    endfunction

    // One access; the bus slave accepts after stall_n stalled cycles and responds wait_n cycles later.
    task automatic xfer(input logic we, input logic [1:0] w, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] dst, input int stall_n,
                        input int wait_n, input logic [31:0] bus, input logic err);
        logic        mis;
        logic [3:0]  sel;
        logic [31:0] wdl, rd;
        logic [1:0]  cause;
        int          resp, done_at, c;
        model(w, a, sg, wd, bus, mis, sel, wdl, rd);
        i_start = 1'b1; i_we = we; i_width = w; i_signed = sg;
        i_addr = a; i_wdata = wd; i_dst_reg = dst;
        step();
        i_start = 1'b0;
        if (mis) begin
            check("mis_done", o_done, 1);
            check("mis_cyc", o_wb_cyc, 0);
            check("mis_cause", o_fault_cause, 2'b01);
            check("mis_fault", o_fault, 1);
            check("mis_rdata", o_rdata, 0);
            check("mis_reg_we", o_reg_we, 0);
            check("mis_dst", o_dst_reg, dst);
            step();
            check("mis_busy_after", o_busy, 0);
            return;
        end
        resp    = stall_n + wait_n;
        done_at = resp + 1;
        cause   = err ? 2'b10 : 2'b00;
`ifdef LSU_TIMEOUT_EN
        if (resp >= 255) begin
            done_at = 255;
            cause   = 2'b11;
        end
`endif
        for (c = 0; c < 600 && !o_done; c++) begin
            check("stb", o_wb_stb, (c <= stall_n) ? 1 : 0);
            check("cyc", o_wb_cyc, 1);
            check("busy", o_busy, 1);
            check("wb_addr", o_wb_addr, {a[31:2], 2'b00});
            check("wb_sel", o_wb_sel, sel);
            check("wb_data", o_wb_data, wdl);
            check("wb_we", o_wb_we, we);
            i_wb_stall = (c < stall_n);
            i_wb_ack   = (c == resp);
            i_wb_err   = (c == resp) && err;
            i_wb_data  = (c == resp) ? bus : $urandom;
            i_start    = 1'($urandom_range(0, 1));
            i_we       = 1'($urandom_range(0, 1));
            i_width    = 2'($urandom_range(0, 3));
            i_addr     = $urandom;
            i_wdata    = $urandom;
            i_dst_reg  = 4'($urandom_range(0, 15));
            step();
        end
        i_start = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
        check("latency", c, done_at);
        check("done", o_done, 1);
        check("done_cyc", o_wb_cyc, 0);
        check("rdata", o_rdata, (we || cause != 2'b00) ? 32'h0 : rd);
        check("dst", o_dst_reg, dst);
        check("reg_we", o_reg_we, (!we && cause == 2'b00) ? 1 : 0);
        check("fault", o_fault, (cause != 2'b00) ? 1 : 0);
        check("cause", o_fault_cause, cause);
        step();
        check("busy_after", o_busy, 0);
        check("done_after", o_done, 0);
    endtask

    initial begin
        step();
        step();
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_stb", o_wb_stb, 0);
        check("rst_sel", o_wb_sel, 0);
        check("rst_addr", o_wb_addr, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_cause", o_fault_cause, 0);
        check("rst_reg_we", o_reg_we, 0);
        reset = 1'b1;
        step();

        xfer(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'd3, 0, 1, 32'hDEADBEEF, 1'b0);
        xfer(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 4'd5, 0, 0, 32'h80123456, 1'b0);
        xfer(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 4'd6, 0, 0, 32'h80123456, 1'b0);
        xfer(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 4'd7, 1, 0, 32'h9ABC0000, 1'b0);
        xfer(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234, 4'd1, 3, 0, 32'h0, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 4'd2, 0, 0, 32'h0, 1'b0);
        xfer(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 4'd2, 0, 0, 32'h0, 1'b0);
        xfer(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 4'd2, 0, 0, 32'h0, 1'b0);
        xfer(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 4'd9, 0, 2, 32'h11111111, 1'b1);
        xfer(1'b1, 2'b10, 1'b0, 32'h404, 32'hCAFEF00D, 4'd9, 2, 0, 32'h0, 1'b1);
        xfer(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 4'd4, 0, 300, 32'h55AA55AA, 1'b0);

        // Reset while the access is waiting for its response
        i_start = 1'b1; i_we = 1'b0; i_width = 2'b10; i_addr = 32'h300; i_dst_reg = 4'd8;
        step();
        i_start = 1'b0;
        step();
        step();
        check("pre_rst_cyc", o_wb_cyc, 1);
        reset = 1'b0;
        #1;
        check("async_rst_cyc", o_wb_cyc, 0);
        check("async_rst_stb", o_wb_stb, 0);
        check("async_rst_busy", o_busy, 0);
        i_wb_ack = 1'b1;
        i_wb_data = 32'h12345678;
        step();
        check("rst_no_done", o_done, 0);
        step();
        check("rst_no_done2", o_done, 0);
        #2 reset = 1'b1;
        step();
        i_wb_ack = 1'b0;
        check("post_rst_done", o_done, 0);
        check("post_rst_busy", o_busy, 0);
        xfer(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 4'd11, 1, 1, 32'h0BADF00D, 1'b0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
